// File: rtl/space_inv_pkg.sv
// Shared types and screen constants for the space-invaders display path.
package space_inv_pkg;
  localparam int CW_DEF   = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [CW_DEF-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, RUN, LANDED} march_state_t;
endpackage

// File: rtl/frame_step_timer.sv
// Counts frames between formation steps; the step period follows the number of aliens left.
module frame_step_timer
  import space_inv_pkg::*;
#(
  parameter int AW         = 6,
  parameter int FRAMES_MIN = 1,
  parameter int FRAMES_MAX = 32
) (
  input  logic          clk_pix,
  input  logic          rst_pix_n,
  input  logic          clear,
  input  logic          advance,
  input  logic [AW-1:0] alive_cnt,
  output logic          step_due
);
  localparam int FW = $clog2(FRAMES_MAX + 1);
  localparam int PW = (AW > FW) ? AW : FW;

  logic [PW-1:0] frame_cnt;
  logic [PW:0]   cnt_inc;
  logic [PW:0]   period;

  function automatic logic [PW:0] clamp_period(input logic [AW-1:0] a);
    logic [PW:0] av;
    av = (PW+1)'(a);
    if (av < (PW+1)'(FRAMES_MIN)) return (PW+1)'(FRAMES_MIN);
    if (av > (PW+1)'(FRAMES_MAX)) return (PW+1)'(FRAMES_MAX);
    return av;
  endfunction

  always_comb begin
    period   = clamp_period(alive_cnt);
    cnt_inc  = {1'b0, frame_cnt} + (PW+1)'(1);
    step_due = advance && (cnt_inc >= period);
  end

  // A shrinking period simply makes the next compare fire early, so the count never overflows.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      frame_cnt <= '0;
    end else if (clear) begin
      frame_cnt <= '0;
    end else if (advance) begin
      frame_cnt <= step_due ? '0 : cnt_inc[PW-1:0];
    end
  end
endmodule

// File: rtl/invader_march_ctrl.sv
// Alien formation sequencer: position, direction and animation phase, updated only on frame pulses.
module invader_march_ctrl
  import space_inv_pkg::*;
#(
  parameter int CW         = 16,
  parameter int X_START    = 144,
  parameter int Y_START    = 64,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 624,
  parameter int FORM_W     = 352,
  parameter int FORM_H     = 128,
  parameter int STEP_X     = 4,
  parameter int STEP_Y     = 16,
  parameter int Y_LIMIT    = 400,
  parameter int FRAMES_MIN = 1,
  parameter int FRAMES_MAX = 32,
  parameter int AW         = 6
) (
  input  logic          clk_pix,
  input  logic          rst_pix_n,
  input  logic          frame,
  input  logic          start,
  input  logic          pause,
  input  logic [AW-1:0] alive_cnt,
  output logic [CW-1:0] form_x,
  output logic [CW-1:0] form_y,
  output logic          dir_left,
  output logic          anim_phase,
  output logic          step_pulse,
  output logic          landed,
  output logic          busy
);
  localparam logic [CW:0]   X_MIN_E   = (CW+1)'(X_MIN);
  localparam logic [CW:0]   X_MAX_E   = (CW+1)'(X_MAX);
  localparam logic [CW:0]   FORM_W_E  = (CW+1)'(FORM_W);
  localparam logic [CW:0]   FORM_H_E  = (CW+1)'(FORM_H);
  localparam logic [CW:0]   STEP_X_E  = (CW+1)'(STEP_X);
  localparam logic [CW:0]   STEP_Y_E  = (CW+1)'(STEP_Y);
  localparam logic [CW:0]   Y_LIMIT_E = (CW+1)'(Y_LIMIT);
  localparam logic [CW-1:0] STEP_X_C  = CW'(STEP_X);

  march_state_t  state;
  logic          frame_ok;
  logic          advance;
  logic          step_due;
  logic          hit_right;
  logic          hit_left;
  logic          drop;
  logic          land;
  logic [CW:0]   y_drop;
  logic [CW-1:0] x_step;

  assign frame_ok = frame && !pause && !start && (state == RUN);
  assign advance  = frame_ok && (alive_cnt != '0);

  frame_step_timer #(
    .AW         (AW),
    .FRAMES_MIN (FRAMES_MIN),
    .FRAMES_MAX (FRAMES_MAX)
  ) u_timer (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .clear      (start),
    .advance    (advance),
    .alive_cnt  (alive_cnt),
    .step_due   (step_due)
  );

  // Edge tests run one bit wider than the coordinates so the sums cannot wrap.
  always_comb begin
    hit_right = ({1'b0, form_x} + FORM_W_E + STEP_X_E) > X_MAX_E;
    hit_left  = {1'b0, form_x} < (X_MIN_E + STEP_X_E);
    drop      = dir_left ? hit_left : hit_right;
    y_drop    = {1'b0, form_y} + STEP_Y_E;
    land      = (y_drop + FORM_H_E) >= Y_LIMIT_E;
    x_step    = dir_left ? (form_x - STEP_X_C) : (form_x + STEP_X_C);
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state      <= IDLE;
      form_x     <= CW'(X_START);
      form_y     <= CW'(Y_START);
      dir_left   <= 1'b0;
      anim_phase <= 1'b0;
      step_pulse <= 1'b0;
      landed     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (start) begin
        state      <= RUN;
        form_x     <= CW'(X_START);
        form_y     <= CW'(Y_START);
        dir_left   <= 1'b0;
        anim_phase <= 1'b0;
        landed     <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (frame_ok && (alive_cnt == '0)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (step_due) begin
              step_pulse <= 1'b1;
              anim_phase <= !anim_phase;
              if (drop) begin
                form_y   <= y_drop[CW-1:0];
                dir_left <= !dir_left;
                if (land) begin
                  state  <= LANDED;
                  landed <= 1'b1;
                  busy   <= 1'b0;
                end
              end else begin
                form_x <= x_step;
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_invader_march_ctrl.sv
// Directed bench for invader_march_ctrl with default parameters.
module tb_invader_march_ctrl;
  logic        clk_pix = 1'b0;
  logic        rst_pix_n;
  logic        frame;
  logic        start;
  logic        pause;
  logic [5:0]  alive_cnt;
  logic [15:0] form_x;
  logic [15:0] form_y;
  logic        dir_left;
  logic        anim_phase;
  logic        step_pulse;
  logic        landed;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int steps  = 0;

  invader_march_ctrl dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .frame      (frame),
    .start      (start),
    .pause      (pause),
    .alive_cnt  (alive_cnt),
    .form_x     (form_x),
    .form_y     (form_y),
    .dir_left   (dir_left),
    .anim_phase (anim_phase),
    .step_pulse (step_pulse),
    .landed     (landed),
    .busy       (busy)
  );

  always #20 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    #5;
    if (step_pulse === 1'b1) steps++;
  end

  typedef struct {
    int         n;
    logic [5:0] alive;
    logic       pse;
    int         nsteps;
    int         x;
    int         y;
    logic       dl;
    logic       an;
    logic       bsy;
    logic       lnd;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_frame;
    frame = 1'b1;
    @(negedge clk_pix);
    frame = 1'b0;
    @(negedge clk_pix);
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clk_pix);
    start = 1'b0;
    @(negedge clk_pix);
  endtask

  initial begin
    int s0;
    rst_pix_n = 1'b0;
    frame     = 1'b0;
    start     = 1'b0;
    pause     = 1'b0;
    alive_cnt = 6'd1;

    vt[0] = '{10, 6'd1,  1'b0, 10, 184, 64, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{22, 6'd1,  1'b0, 22, 272, 64, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1,  6'd1,  1'b0, 1,  272, 80, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1,  6'd1,  1'b0, 1,  268, 80, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{5,  6'd1,  1'b1, 0,  268, 80, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{31, 6'd40, 1'b0, 0,  268, 80, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1,  6'd40, 1'b0, 1,  264, 80, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (2) @(negedge clk_pix);
    chk("rst_x", form_x, 144);
    chk("rst_y", form_y, 64);
    chk("rst_dir", dir_left, 0);
    chk("rst_anim", anim_phase, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_landed", landed, 0);
    chk("rst_busy", busy, 0);
    rst_pix_n = 1'b1;
    @(negedge clk_pix);

    // Asynchronous reset in the middle of a march
    do_start;
    repeat (3) do_frame;
    chk("pre_rst_x", form_x, 156);
    #7 rst_pix_n = 1'b0;
    #1;
    chk("mid_rst_x", form_x, 144);
    chk("mid_rst_y", form_y, 64);
    chk("mid_rst_dir", dir_left, 0);
    chk("mid_rst_landed", landed, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(negedge clk_pix);

    // Table: one continuous march from a fresh start
    alive_cnt = 6'd1;
    do_start;
    for (int i = 0; i < 7; i++) begin
      alive_cnt = vt[i].alive;
      pause     = vt[i].pse;
      s0        = steps;
      repeat (vt[i].n) do_frame;
      chk($sformatf("v%0d_steps", i), steps - s0, vt[i].nsteps);
      chk($sformatf("v%0d_x", i), form_x, vt[i].x);
      chk($sformatf("v%0d_y", i), form_y, vt[i].y);
      chk($sformatf("v%0d_dir", i), dir_left, vt[i].dl);
      chk($sformatf("v%0d_anim", i), anim_phase, vt[i].an);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("v%0d_landed", i), landed, vt[i].lnd);
    end
    pause = 1'b0;

    // Slow period: 31 frames idle, step lands exactly one cycle after the 32nd
    alive_cnt = 6'd40;
    do_start;
    s0 = steps;
    repeat (31) do_frame;
    chk("slow_nostep", steps - s0, 0);
    chk("slow_x31", form_x, 144);
    frame = 1'b1;
    @(negedge clk_pix);
    frame = 1'b0;
    chk("slow_pulse", step_pulse, 1);
    chk("slow_x32", form_x, 148);
    @(negedge clk_pix);
    chk("slow_pulse_end", step_pulse, 0);

    // March to the landing line
    alive_cnt = 6'd1;
    do_start;
    for (int k = 0; k < 2000 && landed !== 1'b1; k++) do_frame;
    chk("land_flag", landed, 1);
    chk("land_y", form_y, 272);
    chk("land_busy", busy, 0);
    chk("land_dir", dir_left, 1);
    chk("land_x", form_x, 272);
    s0 = steps;
    repeat (5) do_frame;
    chk("land_frozen_steps", steps - s0, 0);
    chk("land_frozen_y", form_y, 272);
    do_start;
    chk("restart_busy", busy, 1);
    chk("restart_landed", landed, 0);
    chk("restart_x", form_x, 144);
    chk("restart_y", form_y, 64);

    // start and frame together: reload wins, no step
    repeat (3) do_frame;
    chk("pre_sf_x", form_x, 156);
    start = 1'b1;
    frame = 1'b1;
    @(negedge clk_pix);
    start = 1'b0;
    frame = 1'b0;
    chk("sf_pulse", step_pulse, 0);
    chk("sf_x", form_x, 144);
    chk("sf_anim", anim_phase, 0);
    @(negedge clk_pix);

    // Wave cleared: back to IDLE, frames ignored afterwards
    alive_cnt = 6'd0;
    do_frame;
    chk("clear_busy", busy, 0);
    chk("clear_x", form_x, 144);
    alive_cnt = 6'd1;
    s0 = steps;
    do_frame;
    chk("idle_steps", steps - s0, 0);
    chk("idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
